// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word request with fixed wait states,
// byte-strobed stores, and a range/alignment error response.
module dmem_responder #(
    parameter int unsigned MEM_POWER   = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH     = 1 << MEM_POWER;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_write;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_mem [0:DEPTH-1];

    logic [1:0]           w_state_nxt;
    logic [3:0]           w_cnt_nxt;
    logic                 w_req_ready_nxt;
    logic                 w_rsp_valid_nxt;
    logic [31:0]          w_rsp_rdata_nxt;
    logic                 w_rsp_err_nxt;
    logic                 w_capture;
    logic                 w_mem_we;
    logic [31:0]          w_off;
    logic                 w_err;
    logic [MEM_POWER-1:0] w_idx;
    logic [31:0]          w_rd_word;

    // Address decode of the captured request; wrap below BASE_ADDR lands out of range.
    assign w_off     = r_addr - BASE_ADDR;
    assign w_err     = (r_addr[1:0] != 2'b00) || ({1'b0, w_off} >= MEM_BYTES);
    assign w_idx     = w_off[MEM_POWER+1:2];
    assign w_rd_word = r_mem[w_idx];

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_capture       = 1'b0;
        w_mem_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_EXEC;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_EXEC: begin
                w_state_nxt     = ST_RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = w_err;
                w_rsp_rdata_nxt = (w_err || r_write) ? 32'd0 : w_rd_word;
                w_mem_we        = r_write && !w_err;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_capture) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
        end
    end

    // Storage is not reset; an async reset drops r_state out of EXEC before any write edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_rsp_ready = 1'b1;
    logic [31:0] a_req_addr = 32'd0, a_req_wdata = 32'd0;
    logic [3:0]  a_req_wstrb = 4'd0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b1;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic [3:0]  b_req_wstrb = 4'd0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.MEM_POWER(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err)
    );

    dmem_responder #(.MEM_POWER(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request to the WAIT_CYCLES=2 instance and return just after the acceptance edge.
    task automatic send_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_req_wstrb = st;
        a_req_valid = 1'b1;
        for (int i = 0; i < 20 && !a_req_ready; i++) step();
        check("a_accept_ready", 32'(a_req_ready), 32'd1);
        step();
        a_req_valid = 1'b0;
    endtask

    // lat = edges after acceptance until rsp_valid is registered high.
    task automatic wait_rsp_a(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        while (!a_rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("a_rsp_seen", 32'(a_rsp_valid), 32'd1);
        rd = a_rsp_rdata;
        er = a_rsp_err;
        if (a_rsp_ready) step();
    endtask

    task automatic xact_a(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        send_a(wr, addr, wd, st);
        wait_rsp_a(rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_done"}, {30'd0, a_rsp_valid, a_req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          e;
        int          acc_edges[$];
        logic        acc;

        step();
        step();
        check("rst_a_outs", {a_req_ready, a_rsp_valid, a_rsp_err, 29'd0}, 32'd0);
        check("rst_a_rdata", a_rsp_rdata, 32'd0);
        reset = 1'b1;
        check("rel_ready_low", 32'(a_req_ready), 32'd0);
        step();
        check("rel_ready_high", {30'd0, a_req_ready, b_req_ready}, 32'd3);

        xact_a("st_full",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'd0,        1'b0);
        xact_a("ld_full",  1'b0, 32'h10,  32'd0,        4'h0, 32'hDEADBEEF, 1'b0);
        xact_a("st_part",  1'b1, 32'h10,  32'h00AA0000, 4'b0100, 32'd0,     1'b0);
        xact_a("ld_part",  1'b0, 32'h10,  32'd0,        4'h0, 32'hDEAABEEF, 1'b0);
        xact_a("st_w0",    1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'd0,        1'b0);
        xact_a("st_last",  1'b1, 32'h3FC, 32'h5A5A1234, 4'hF, 32'd0,        1'b0);
        xact_a("ld_mis",   1'b0, 32'h12,  32'd0,        4'h0, 32'd0,        1'b1);
        xact_a("ld_oor",   1'b0, 32'h400, 32'd0,        4'h0, 32'd0,        1'b1);
        xact_a("st_oor",   1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'd0,        1'b1);
        xact_a("ld_w0",    1'b0, 32'h0,   32'd0,        4'h0, 32'hCAFEF00D, 1'b0);
        xact_a("ld_last",  1'b0, 32'h3FC, 32'd0,        4'h0, 32'h5A5A1234, 1'b0);
        xact_a("st_nostb", 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'd0,        1'b0);

        // Response backpressure with a second request waiting.
        a_rsp_ready = 1'b0;
        send_a(1'b0, 32'h10, 32'd0, 4'h0);
        wait_rsp_a(rd, er, lat);
        check("bp_lat", 32'(lat), 32'd3);
        check("bp_rdata0", rd, 32'hDEAABEEF);
        a_req_write = 1'b0;
        a_req_addr  = 32'h3FC;
        a_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_flags", {29'd0, a_rsp_valid, a_rsp_err, a_req_ready}, 32'd4);
            check("bp_hold_rdata", a_rsp_rdata, 32'hDEAABEEF);
        end
        a_rsp_ready = 1'b1;
        step();
        check("bp_release", {30'd0, a_rsp_valid, a_req_ready}, 32'd1);
        step();
        check("bp_second_acc", 32'(a_req_ready), 32'd0);
        a_req_valid = 1'b0;
        wait_rsp_a(rd, er, lat);
        check("bp2_lat", 32'(lat), 32'd3);
        check("bp2_rdata", rd, 32'h5A5A1234);

        // Zero-wait instance: one store, then back-to-back loads with the request held.
        b_req_write = 1'b1;
        b_req_addr  = 32'h8;
        b_req_wdata = 32'h0BADF00D;
        b_req_wstrb = 4'hF;
        b_req_valid = 1'b1;
        for (int i = 0; i < 20 && !b_req_ready; i++) step();
        step();
        b_req_valid = 1'b0;
        check("b_st_lat0", 32'(b_rsp_valid), 32'd0);
        step();
        check("b_st_lat1", {30'd0, b_rsp_valid, b_rsp_err}, 32'd2);
        step();
        b_req_write = 1'b0;
        b_req_valid = 1'b1;
        e = 0;
        for (int i = 0; i < 13; i++) begin
            acc = b_req_ready;
            step();
            e++;
            if (acc) begin
                acc_edges.push_back(e);
                check("b_acc_no_rsp", 32'(b_rsp_valid), 32'd0);
            end else if (acc_edges.size() > 0 && e == acc_edges[$] + 1) begin
                check("b_rsp_valid", {30'd0, b_rsp_valid, b_rsp_err}, 32'd2);
                check("b_rsp_rdata", b_rsp_rdata, 32'h0BADF00D);
            end
        end
        b_req_valid = 1'b0;
        check("b_acc_count", 32'(acc_edges.size()), 32'd5);
        for (int i = 1; i < acc_edges.size(); i++) begin
            check("b_acc_gap", 32'(acc_edges[i] - acc_edges[i-1]), 32'd3);
        end
        step();
        step();

        // Reset during WAIT of a store drops it.
        xact_a("st_20_old", 1'b1, 32'h20, 32'h0, 4'hF, 32'd0, 1'b0);
        send_a(1'b1, 32'h20, 32'h12345678, 4'hF);
        step();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {29'd0, a_req_ready, a_rsp_valid, a_rsp_err}, 32'd0);
        step();
        step();
        check("mid_rst_norsp", {30'd0, a_rsp_valid, a_req_ready}, 32'd0);
        reset = 1'b1;
        step();
        check("mid_rst_ready", 32'(a_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("mid_rst_quiet", 32'(a_rsp_valid), 32'd0);
        xact_a("ld_20", 1'b0, 32'h20, 32'd0, 4'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
